// File: rtl/bram_sp_arbiter.sv
// bram_sp_arbiter
// Two-requester controller for one synchronous single-port block RAM.
// After reset it can sweep every RAM word to CLEAR_VALUE. It then grants one
// access per clock, round-robin, using valid/ready handshakes. Read data comes
// back to the requester that issued the read, two clocks after acceptance.

module bram_sp_arbiter #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 4,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_wr,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_data,
    output logic                  a_rsp_valid,
    output logic [DATA_WIDTH-1:0] a_rsp_data,

    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_req_wr,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_data,
    output logic                  b_rsp_valid,
    output logic [DATA_WIDTH-1:0] b_rsp_data,

    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,

    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // The counter is one bit wider than the address so that the terminal
    // count cannot be confused with a wrapped counter.
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR,
        ST_ARB
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH:0]   clear_cnt;

    // Round-robin preference: 0 = A preferred, 1 = B preferred.
    logic                  rr_b;

    // One-stage read tag that follows an accepted read while the RAM works.
    logic                  tag_valid;
    logic                  tag_port;

    logic                  grant_a;
    logic                  grant_b;
    logic [ADDR_WIDTH-1:0] last_addr;

    // Grant decision: a lone requester wins; under contention the rr pointer decides.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst && state == ST_ARB) begin
            if (a_req_valid && b_req_valid) begin
                grant_a = ~rr_b;
                grant_b = rr_b;
            end else begin
                grant_a = a_req_valid;
                grant_b = b_req_valid;
            end
        end
    end

    assign a_req_ready = grant_a;
    assign b_req_ready = grant_b;

    // RAM port mux: the clear sweep, else the granted requester, else idle.
    // An idle address holds its last value.
    always_comb begin
        mem_wr   = 1'b0;
        mem_addr = last_addr;
        mem_din  = '0;
        if (!rst && state == ST_CLEAR) begin
            mem_wr   = 1'b1;
            mem_addr = clear_cnt[ADDR_WIDTH-1:0];
            mem_din  = CLEAR_VALUE;
        end else if (grant_a) begin
            mem_wr   = a_req_wr;
            mem_addr = a_req_addr;
            mem_din  = a_req_data;
        end else if (grant_b) begin
            mem_wr   = b_req_wr;
            mem_addr = b_req_addr;
            mem_din  = b_req_data;
        end
    end

    // Remember the last driven RAM address so that it stays stable on idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_addr <= '0;
        end else begin
            last_addr <= mem_addr;
        end
    end

    // Sequencing: run the clear sweep once after reset, then stay in arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;
            clear_cnt <= '0;
            busy      <= CLEAR_ON_RESET;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clear_cnt <= clear_cnt + 1'b1;
                    if (clear_cnt == LAST_ADDR) begin
                        state <= ST_ARB;
                        busy  <= 1'b0;
                    end
                end
                ST_ARB: begin
                    state <= ST_ARB;
                end
                default: begin
                    state <= ST_ARB;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Round-robin update: only a contended cycle moves the pointer, to the loser.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_b <= 1'b0;
        end else if (state == ST_ARB && a_req_valid && b_req_valid) begin
            rr_b <= grant_a;
        end
    end

    // Tag every accepted read with its port while the RAM produces the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid <= 1'b0;
            tag_port  <= 1'b0;
        end else begin
            tag_valid <= (grant_a & ~a_req_wr) | (grant_b & ~b_req_wr);
            tag_port  <= grant_b;
        end
    end

    // Return read data to the tagged port as a one-cycle pulse.
    // Each port's data holds its value between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rsp_valid <= 1'b0;
            a_rsp_data  <= '0;
            b_rsp_valid <= 1'b0;
            b_rsp_data  <= '0;
        end else begin
            a_rsp_valid <= tag_valid & ~tag_port;
            b_rsp_valid <= tag_valid & tag_port;
            if (tag_valid && !tag_port) begin
                a_rsp_data <= mem_dout;
            end
            if (tag_valid && tag_port) begin
                b_rsp_data <= mem_dout;
            end
        end
    end

endmodule
